jtpang_objdma: RTL
==================

# jtpang_objdma

Object-table DMA controller for the Pang video subsystem. On a CPU DMA trigger it requests the Z80 bus, walks the 512-byte object area of the shared video RAM through `dma_addr`, and copies each byte into the object line engine's double-buffered table. It owns the `busrq`/`busak_n` handshake and the table bank swap, and sits between the CPU decoder, the char/VRAM block and the object engine inside `jtpang_video`.

## Interface
Parameters:
- `LEN`, 512: bytes per transfer; must be a power of two, at most 512.

Ports:
- `clk`  in  1  system clock (48 MHz domain); the only clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `cen`  in  1  step enable; all state advances only on `clk` edges with `cen`=1.
- `LVBL`  in  1  vertical blank, active-low.
- `dma_go`  in  1  CPU trigger; rising edge sampled on `cen`.
- `busak_n`  in  1  Z80 bus acknowledge, active-low.
- `busrq`  out  1  Z80 bus request, active-high.
- `dma_addr`  out  9  VRAM read address, driven to the char block.
- `dma_din`  in  8  VRAM read data, valid one `cen` after `dma_addr`.
- `tbl_we`  out  1  table write strobe, one `cen` wide.
- `tbl_addr`  out  10  table write address, `{~bank, byte index}`.
- `tbl_din`  out  8  table write data.
- `bank`  out  1  table half currently read by the object engine.
- `busy`  out  1  high from trigger acceptance until the bus is released.

## Operation
- States: IDLE, REQ, XFER, FLUSH, REL.
- IDLE: `busrq`=0. A `dma_go` rising edge, or a set `pending` flag, moves to REQ and clears `pending`.
- REQ: `busrq`=1. Stays until `busak_n`=0 is sampled, then enters XFER with the address counter at 0.
- XFER: each `cen` presents the counter on `dma_addr` and increments it. The write stage is one `cen` behind: `tbl_we`=1, `tbl_addr`={~bank, previous counter}, `tbl_din`=`dma_din`. After address LEN-1 is presented, the state moves to FLUSH.
- FLUSH: performs the last write (index LEN-1) and sets `swap_pend`. `busrq` drops at this step.
- REL: `busrq`=0. Waits until `busak_n`=1 is sampled, then returns to IDLE.
- A `dma_go` edge seen in any non-IDLE state sets `pending`. A second edge while `pending` is already set is absorbed. The current transfer is never restarted.
- If `busak_n` goes high during XFER (bus stolen), the counter and writes freeze and `busrq` stays 1. The transfer resumes at the same address when `busak_n` returns low.
- Bank swap: `bank` toggles on the first `cen` with an LVBL falling edge while `swap_pend`=1, then `swap_pend` clears. A swap never happens mid-frame.
- The byte index is 9 bits. The counter wraps to 0 only via the IDLE→REQ path; it never wraps inside a transfer.

## Timing
- Reset values: `busrq`=0, `dma_addr`=0, `tbl_we`=0, `tbl_addr`=0, `tbl_din`=0, `bank`=0, `busy`=0. The state machine is in IDLE with `pending`=0 and `swap_pend`=0.
- Reset mid-transfer drops `busrq` immediately (asynchronously). The partial table contents are left as they are.
- Latency, counted in `cen` steps: `dma_go` edge to `busrq`=1 is 1 step. `busak_n` low to the first `dma_addr` is 1 step. The first `tbl_we` follows 1 step later.
- A transfer with no bus steals takes LEN+1 `cen` steps from the first `dma_addr` to `busrq`=0.
- `busy` rises with `busrq` and falls on entry to IDLE.
- If `dma_go` rises and `busak_n` changes on the same `cen`, both are processed: the edge is recorded and the handshake advances.

## Configuration
- `JTPANG_DMA_VBL_EN`:
  - Defined: IDLE→REQ is additionally gated by `LVBL`=0, so a trigger arriving during active video waits in `pending` until vertical blank. The bank swap then occurs at the next LVBL falling edge after completion, as normal.
  - Undefined: requests start immediately, regardless of `LVBL`.

## Test plan
- Basic transfer: VRAM byte n holds n^8'h5A. Pulse `dma_go`, then ack 3 steps later. Expect 512 `tbl_we` pulses with `tbl_addr`={1'b1,n} and data n^8'h5A, `busrq`=0 after the last write, and `bank`=1 after the next LVBL fall.
- Bus steal: deassert `busak_n` for 10 steps at index 200. Expect no writes during the steal, a resume at index 200, and 512 unique writes in total.
- Retrigger: a `dma_go` edge at index 100 gives exactly one additional full transfer after REL, and that transfer writes into `{1'b0, n}` once `bank`=1.
- Reset at index 300: `busrq`=0 in the same clock, all outputs at reset values, and the next `dma_go` restarts at index 0.
- Ack ordering: `busak_n` held high for 50 steps. Expect `busrq` held 1, no `dma_addr` advance, and no writes.
- With `JTPANG_DMA_VBL_EN`: `dma_go` at LVBL=1 gives `busrq`=0 until LVBL falls, then 1 one step later.

Source files
------------

// File: rtl/jtpang_objdma_if.sv
// jtpang_objdma_if: Z80 bus handshake, VRAM read port and object table write port
// seen from the DMA controller (master) and its environment (slave).
interface jtpang_objdma_if;
    logic       busrq;
    logic       busak_n;
    logic [8:0] dma_addr;
    logic [7:0] dma_din;
    logic       tbl_we;
    logic [9:0] tbl_addr;
    logic [7:0] tbl_din;
    modport master(output busrq, dma_addr, tbl_we, tbl_addr, tbl_din, input busak_n, dma_din);
    modport slave(input busrq, dma_addr, tbl_we, tbl_addr, tbl_din, output busak_n, dma_din);
endinterface

// File: rtl/jtpang_objdma.sv
// jtpang_objdma: copies the VRAM object area into the idle half of the object table.
// Optional JTPANG_DMA_VBL_EN: a trigger only starts the transfer during vertical blank.
module jtpang_objdma #(
    parameter int LEN = 512
) (
    input  logic clk,
    input  logic rst,
    input  logic cen,
    input  logic LVBL,
    input  logic dma_go,
    output logic bank,
    output logic busy,
    jtpang_objdma_if.master bus
);
    localparam logic [2:0] IDLE = 3'd0, REQ = 3'd1, XFER = 3'd2, FLUSH = 3'd3, REL = 3'd4;
    localparam logic [8:0] LAST = 9'(LEN - 1);

    logic [2:0] st;
    logic [8:0] addr;
    logic [9:0] wr_a;
    logic       wr_v, rq, go_l, lvbl_l, pending, swap_pend;
    logic       go_edge, vbl_fall, start;

    assign go_edge  = dma_go & ~go_l;
    assign vbl_fall = lvbl_l & ~LVBL;
`ifdef JTPANG_DMA_VBL_EN
    assign start = (go_edge | pending) & ~LVBL;
`else
    assign start = go_edge | pending;
`endif

    assign bus.busrq    = rq;
    assign bus.dma_addr = addr;
    assign bus.tbl_we   = wr_v;
    assign bus.tbl_addr = wr_a;
    // VRAM data arrives one step after its address, i.e. during the write step
    assign bus.tbl_din  = wr_v ? bus.dma_din : 8'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= IDLE;
            addr      <= 9'd0;
            wr_a      <= 10'd0;
            wr_v      <= 1'b0;
            rq        <= 1'b0;
            go_l      <= 1'b0;
            lvbl_l    <= 1'b0;
            pending   <= 1'b0;
            swap_pend <= 1'b0;
            bank      <= 1'b0;
            busy      <= 1'b0;
        end else if (cen) begin
            go_l    <= dma_go;
            lvbl_l  <= LVBL;
            wr_v    <= 1'b0;
            wr_a    <= 10'd0;
            pending <= pending | go_edge;
            if (swap_pend && vbl_fall) begin
                bank      <= ~bank;
                swap_pend <= 1'b0;
            end
            case (st)
                IDLE: if (start) begin
                    st      <= REQ;
                    rq      <= 1'b1;
                    busy    <= 1'b1;
                    addr    <= 9'd0;
                    pending <= 1'b0;
                end
                REQ: if (!bus.busak_n) st <= XFER;
                // a stolen bus freezes both the address and the write stage
                XFER: if (!bus.busak_n) begin
                    wr_v <= 1'b1;
                    wr_a <= {~bank, addr};
                    if (addr == LAST) st <= FLUSH;
                    else addr <= addr + 9'd1;
                end
                FLUSH: begin
                    st        <= REL;
                    rq        <= 1'b0;
                    swap_pend <= 1'b1;
                end
                REL: if (bus.busak_n) begin
                    st   <= IDLE;
                    busy <= 1'b0;
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule
